entry_alloc_dec: RTL

Parametrised one-hot entry allocator for the miniCPU. It tracks the busy/free state of 2^IDX_W entries, such as physical registers, buffer slots or TLB entries. Each cycle it grants at most one free entry, returned as both a binary index and a decoded one-hot vector. It accepts at most one release by index per cycle. It is the stateful successor of the fixed-width 2-4 / 4-16 / 5-32 / 6-64 decoders: the width is a parameter, and it adds allocation policy, occupancy counting and error flagging.

---
 rtl/entry_alloc_dec.sv | 114 +++++++++++
 1 files changed

// File: rtl/entry_alloc_dec.sv
// Entry allocator: tracks busy/free state of 2^IDX_W entries and grants at most
// one free entry per cycle (binary index + one-hot), with one release per cycle.
module entry_alloc_dec #(
    parameter int IDX_W   = 5,
    parameter int RR_MODE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alloc_req,
    output logic                  alloc_gnt,
    output logic [IDX_W-1:0]      alloc_idx,
    output logic [(1<<IDX_W)-1:0] alloc_oh,
    input  logic                  free_valid,
    input  logic [IDX_W-1:0]      free_idx,
    output logic [(1<<IDX_W)-1:0] busy_vec,
    output logic [IDX_W:0]        free_cnt,
    output logic                  empty,
    output logic                  free_err
);

    localparam int N = 1 << IDX_W;
    localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(N);

    logic [N-1:0]     r_busy_vec;
    logic [IDX_W:0]   r_free_cnt;
    logic [IDX_W-1:0] r_rr_ptr;
    logic             r_free_err;

    logic [N-1:0]     w_free_vec;
    logic [N-1:0]     w_rot_free;
    logic [IDX_W-1:0] w_lo_idx;
    logic [IDX_W-1:0] w_rr_off;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_legal_free;
    logic             w_illegal_free;
    logic [N-1:0]     w_legal_free_oh;
    logic [IDX_W:0]   w_free_cnt_next;

    function automatic logic [IDX_W-1:0] f_lowest_set(input logic [N-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    assign w_free_vec = ~r_busy_vec;

    // Rotating the free map so bit 0 is the pointer turns round-robin into a
    // plain lowest-set search; the index sum wraps modulo N by its width.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign w_rot_free[gi] = w_free_vec[r_rr_ptr + IDX_W'(gi)];
        end
    endgenerate

    assign w_lo_idx  = f_lowest_set(w_free_vec);
    assign w_rr_off  = f_lowest_set(w_rot_free);
    assign w_sel_idx = (RR_MODE != 0) ? (r_rr_ptr + w_rr_off) : w_lo_idx;

    assign alloc_gnt = alloc_req && (r_free_cnt != '0);
    assign alloc_idx = alloc_gnt ? w_sel_idx : '0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dec
            assign alloc_oh[gi]        = alloc_gnt && (alloc_idx == IDX_W'(gi));
            assign w_legal_free_oh[gi] = w_legal_free && (free_idx == IDX_W'(gi));
        end
    endgenerate

    // Frees are judged against the start-of-cycle map, so freeing the entry
    // being granted right now counts as illegal.
    assign w_legal_free   = free_valid && r_busy_vec[free_idx];
    assign w_illegal_free = free_valid && !r_busy_vec[free_idx];

    always_comb begin
        w_free_cnt_next = r_free_cnt;
        case ({w_legal_free, alloc_gnt})
            2'b10:   w_free_cnt_next = r_free_cnt + (IDX_W+1)'(1);
            2'b01:   w_free_cnt_next = r_free_cnt - (IDX_W+1)'(1);
            default: w_free_cnt_next = r_free_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy_vec <= '0;
            r_free_cnt <= CNT_FULL;
            r_rr_ptr   <= '0;
            r_free_err <= 1'b0;
        end else begin
            r_busy_vec <= (r_busy_vec & ~w_legal_free_oh) | alloc_oh;
            r_free_cnt <= w_free_cnt_next;
            r_free_err <= w_illegal_free;
            if (alloc_gnt) begin
                r_rr_ptr <= alloc_idx + IDX_W'(1);
            end
        end
    end

    assign busy_vec = r_busy_vec;
    assign free_cnt = r_free_cnt;
    assign empty    = (r_free_cnt == '0);
    assign free_err = r_free_err;

    a_cnt_consistent: assert property (@(posedge clk) disable iff (reset)
        r_free_cnt == CNT_FULL - (IDX_W+1)'($countones(r_busy_vec)));

    a_oh_single: assert property (@(posedge clk) $onehot0(alloc_oh));

endmodule
